// File: rtl/n_serial_rx.sv
// Nintendo serial pulse-width receiver: decodes short-low '1' / long-low '0' pulses into bytes and stop-bit events.
// Define N_SERIAL_RX_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchroniser (+2 clk edge latency).
module n_serial_rx #(
  parameter int US_CYCLES = 5,
  parameter int IDLE_US   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_stopbit,
  output logic       rx_error
);

  localparam int T0    = 2 * US_CYCLES;
  localparam int TMAX  = 4 * US_CYCLES;
  localparam int TIDLE = IDLE_US * US_CYCLES;
  localparam int CW    = $clog2(TIDLE + TMAX + 2);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t T0_C    = cnt_t'(T0);
  localparam cnt_t TMAX_C  = cnt_t'(TMAX);
  localparam cnt_t TIDLE_C = cnt_t'(TIDLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_RESYNC
  } state_t;

  state_t     state;
  logic       sync1, sync2;
  logic       line, line_d;
  logic       rise, fall;
  logic       new_bit;
  cnt_t       low_cnt, high_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

`ifdef N_SERIAL_RX_GLITCH_FILTER_EN
  logic [1:0] hist;

  // Registered majority vote: a lone sample never wins, and the output lags sync2 by two cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '1;
      line <= 1'b1;
    end else begin
      hist <= {hist[0], sync2};
      line <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    end
  end
`else
  assign line = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line_d <= 1'b1;
    else        line_d <= line;
  end

  assign rise    = line & ~line_d;
  assign fall    = ~line & line_d;
  assign new_bit = (low_cnt < T0_C);

  // Each counter holds at zero while the line is at the opposite level, so it restarts on every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (line)               low_cnt <= '0;
      else if (low_cnt != '1) low_cnt <= low_cnt + cnt_t'(1);
      if (!line)               high_cnt <= '0;
      else if (high_cnt != '1) high_cnt <= high_cnt + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_strobe  <= 1'b0;
      rx_stopbit <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      rx_strobe  <= 1'b0;
      rx_stopbit <= 1'b0;
      rx_error   <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (fall) begin
            state <= S_LOW;
            busy  <= 1'b1;
          end
        end
        S_LOW: begin
          if (low_cnt > TMAX_C) begin
            rx_error <= 1'b1;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= S_RESYNC;
          end else if (rise) begin
            shreg   <= {shreg[5:0], new_bit};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data   <= {shreg, new_bit};
              rx_strobe <= 1'b1;
            end
            state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state <= S_LOW;
          end else if (line && high_cnt == TIDLE_C) begin
            // A single pulse after the last full byte is the stop bit; any other count is a framing error.
            if (bit_cnt == 3'd1) rx_stopbit <= 1'b1;
            else                 rx_error   <= 1'b1;
            bit_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_RESYNC: begin
          busy <= 1'b1;
          if (line && high_cnt >= TIDLE_C) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
